// File: rtl/dram_stride_burst_ctrl.sv
// Strided/broadcast DRAM burst sequencer: latches operands on start and issues up to LANES one-hot-lane beats.
// Registered outputs; first beat one cycle after start is sampled; start is ignored while busy.
module dram_stride_burst_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int STRIDE_W = 7,
    parameter int LANES    = 4,
    parameter int LEN_W    = $clog2(LANES) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                write_en,
    input  logic                strided,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [STRIDE_W-1:0] stride,
    input  logic [LEN_W-1:0]    len,
    output logic [LANES-1:0]    lane_en,
    output logic [ADDR_W-1:0]   dram_address,
    output logic                dram_we,
    output logic [LEN_W-1:0]    beat_idx,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_n;

    logic [ADDR_W-1:0] stride_q;
    logic              strided_q;
    logic              we_q;
    logic [LEN_W-1:0]  eff_len_q;
    logic [LEN_W-1:0]  eff_len;
    logic              load;

    logic [LANES-1:0]  lane_n;
    logic [ADDR_W-1:0] addr_n;
    logic              we_n;
    logic [LEN_W-1:0]  beat_n;
    logic              busy_n;
    logic              done_n;

    // A zero or oversized length means a full burst across every lane.
    assign eff_len = ((len == '0) || (len > LEN_W'(LANES))) ? LEN_W'(LANES) : len;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            lane_en      <= '0;
            dram_address <= '0;
            dram_we      <= 1'b0;
            beat_idx     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            stride_q     <= '0;
            strided_q    <= 1'b0;
            we_q         <= 1'b0;
            eff_len_q    <= '0;
        end else begin
            state        <= state_n;
            lane_en      <= lane_n;
            dram_address <= addr_n;
            dram_we      <= we_n;
            beat_idx     <= beat_n;
            busy         <= busy_n;
            done         <= done_n;
            if (load) begin
                stride_q  <= ADDR_W'(stride);
                strided_q <= strided;
                we_q      <= write_en;
                eff_len_q <= eff_len;
            end
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        lane_n  = '0;
        addr_n  = dram_address;
        we_n    = 1'b0;
        beat_n  = beat_idx;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = RUN;
                    load    = 1'b1;
                    lane_n  = {{(LANES-1){1'b0}}, 1'b1};
                    addr_n  = base_addr;
                    we_n    = write_en;
                    beat_n  = '0;
                    busy_n  = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                if (beat_idx == eff_len_q - LEN_W'(1)) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    // Address is accumulated beat by beat rather than multiplied.
                    lane_n = lane_en << 1;
                    addr_n = strided_q ? (dram_address + stride_q) : dram_address;
                    we_n   = we_q;
                    beat_n = beat_idx + LEN_W'(1);
                    busy_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dram_stride_burst_ctrl.sv
// Directed testbench for dram_stride_burst_ctrl: default 4-lane instance plus an 8-lane, 10-bit-address instance.
module tb_dram_stride_burst_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start, write_en, strided;
    logic [7:0] base_addr;
    logic [6:0] stride;
    logic [2:0] len;
    logic [3:0] lane_en;
    logic [7:0] dram_address;
    logic       dram_we, busy, done;
    logic [2:0] beat_idx;

    logic       w_start, w_we, w_strided;
    logic [9:0] w_base;
    logic [6:0] w_stride;
    logic [3:0] w_len;
    logic [7:0] w_lane;
    logic [9:0] w_addr;
    logic       w_dram_we, w_busy, w_done;
    logic [3:0] w_beat;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] obs [0:7];

    dram_stride_burst_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .write_en(write_en), .strided(strided),
        .base_addr(base_addr), .stride(stride), .len(len), .lane_en(lane_en),
        .dram_address(dram_address), .dram_we(dram_we), .beat_idx(beat_idx),
        .busy(busy), .done(done)
    );

    dram_stride_burst_ctrl #(.ADDR_W(10), .STRIDE_W(7), .LANES(8)) dut_wide (
        .clk(clk), .rst(rst), .start(w_start), .write_en(w_we), .strided(w_strided),
        .base_addr(w_base), .stride(w_stride), .len(w_len), .lane_en(w_lane),
        .dram_address(w_addr), .dram_we(w_dram_we), .beat_idx(w_beat),
        .busy(w_busy), .done(w_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge on which done is expected.
    task automatic burst(input string tag, input logic [7:0] b, input logic [6:0] s,
                         input logic [2:0] l, input logic strd, input logic we,
                         input int n, input bit hold, input int poke);
        logic [7:0] ea;
        ea = b;
        base_addr = b; stride = s; len = l; strided = strd; write_en = we; start = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (k == poke) begin
                start = 1'b1; base_addr = 8'hAA; stride = 7'h01; len = 3'd1; write_en = ~we;
            end
            ea = strd ? 8'(int'(b) + k * int'(s)) : b;
            check({tag, "_lane"}, 32'(lane_en), 32'(1) << k);
            check({tag, "_addr"}, 32'(dram_address), 32'(ea));
            check({tag, "_we"}, 32'(dram_we), 32'(we));
            check({tag, "_beat"}, 32'(beat_idx), 32'(k));
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_nodone"}, 32'(done), 32'd0);
            obs[k] = dram_address;
        end
        @(negedge clk);
        if (!hold) start = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
        check({tag, "_done_lane"}, 32'(lane_en), 32'd0);
        check({tag, "_done_we"}, 32'(dram_we), 32'd0);
        check({tag, "_done_addr"}, 32'(dram_address), 32'(ea));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; write_en = 1'b0; strided = 1'b0;
        base_addr = '0; stride = '0; len = '0;
        w_start = 1'b0; w_we = 1'b0; w_strided = 1'b0; w_base = '0; w_stride = '0; w_len = '0;
        repeat (2) @(negedge clk);
        check("rst_lane", 32'(lane_en), 32'd0);
        check("rst_addr", 32'(dram_address), 32'd0);
        check("rst_we", 32'(dram_we), 32'd0);
        check("rst_beat", 32'(beat_idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        start = 1'b1;
        @(negedge clk);
        check("rst_beats_start", 32'(busy), 32'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);

        burst("sld", 8'h10, 7'd16, 3'd4, 1'b1, 1'b0, 4, 1'b0, -1);
        check("sld_b0", 32'(obs[0]), 32'h10);
        check("sld_b3", 32'(obs[3]), 32'h40);
        @(negedge clk);
        check("sld_single_done", 32'(done), 32'd0);

        burst("bst", 8'h22, 7'd9, 3'd0, 1'b0, 1'b1, 4, 1'b0, -1);
        check("bst_b3", 32'(obs[3]), 32'h22);
        @(negedge clk);
        check("bst_single_done", 32'(done), 32'd0);

        burst("short", 8'hF8, 7'd5, 3'd2, 1'b1, 1'b0, 2, 1'b0, -1);
        check("short_b1", 32'(obs[1]), 32'hFD);
        @(negedge clk);
        check("short_idle_lane", 32'(lane_en), 32'd0);

        burst("wrap", 8'hFC, 7'd8, 3'd3, 1'b1, 1'b0, 3, 1'b0, -1);
        check("wrap_b1", 32'(obs[1]), 32'h04);
        check("wrap_b2", 32'(obs[2]), 32'h0C);
        @(negedge clk);

        // Start held high across DONE: second burst follows with no idle gap.
        burst("clamp", 8'h40, 7'd2, 3'd7, 1'b1, 1'b0, 4, 1'b1, -1);
        check("clamp_b3", 32'(obs[3]), 32'h46);
        burst("b2b", 8'h80, 7'd1, 3'd2, 1'b1, 1'b1, 2, 1'b0, -1);
        check("b2b_b1", 32'(obs[1]), 32'h81);
        @(negedge clk);

        burst("ign", 8'h30, 7'd3, 3'd4, 1'b1, 1'b0, 4, 1'b0, 1);
        check("ign_b3", 32'(obs[3]), 32'h39);
        @(negedge clk);
        check("ign_single_done", 32'(done), 32'd0);
        check("ign_idle_busy", 32'(busy), 32'd0);

        base_addr = 8'h50; stride = 7'd4; len = 3'd4; strided = 1'b1; write_en = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_beat2", 32'(beat_idx), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_lane", 32'(lane_en), 32'd0);
        check("mid_rst_addr", 32'(dram_address), 32'd0);
        check("mid_rst_we", 32'(dram_we), 32'd0);
        check("mid_rst_beat", 32'(beat_idx), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        check("mid_rst_nodone", 32'(done), 32'd0);
        burst("post", 8'h60, 7'd1, 3'd4, 1'b1, 1'b1, 4, 1'b0, -1);
        check("post_b3", 32'(obs[3]), 32'h63);
        @(negedge clk);

        w_base = 10'h3E0; w_stride = 7'h40; w_len = 4'd0; w_strided = 1'b1; w_we = 1'b1; w_start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            w_start = 1'b0;
            check("wide_lane", 32'(w_lane), 32'(1) << k);
            check("wide_addr", 32'(w_addr), 32'((32'h3E0 + k * 32'h40) & 32'h3FF));
            check("wide_beat", 32'(w_beat), 32'(k));
            check("wide_we", 32'(w_dram_we), 32'd1);
            if (k == 1) check("wide_wrap", 32'(w_addr), 32'h020);
        end
        @(negedge clk);
        check("wide_done", 32'(w_done), 32'd1);
        check("wide_done_lane", 32'(w_lane), 32'd0);
        check("wide_done_addr", 32'(w_addr), 32'h1A0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
